// File: rtl/otter_lsu.sv
// Load/store initiator for the OTTER data port: one request at a time, splits
// misaligned RAM accesses into byte beats, reassembles load data, rejects illegal requests.
module otter_lsu #(
  parameter logic [31:0] IO_BASE  = 32'h00010000,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic [31:0] mem_addr2,
  output logic [31:0] mem_din2,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_dout2
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, asm_reg, asm_next;
  logic [1:0]  size_reg, beat_reg, last_beat_reg;
  logic        we_reg, sign_reg, split_reg, err_reg;

  logic        accept, is_io, native, split_req, req_err;
  logic [31:0] last_addr;
  logic [7:0]  wdata_byte;

  assign accept = req_valid && (state_reg == IDLE);

  // Request classification, evaluated on the live request at accept time
  always_comb begin
    is_io = req_addr >= IO_BASE;
    case (req_size)
      2'd0:    native = 1'b1;
      2'd1:    native = req_addr[1:0] != 2'b11;
      2'd2:    native = req_addr[1:0] == 2'b00;
      default: native = 1'b0;
    endcase
    last_addr = req_addr + ((req_size == 2'd1) ? 32'd1 : 32'd3);
    split_req = !is_io && !native && (req_size != 2'd3);
    req_err   = (req_size == 2'd3)
             || (is_io && (((req_size == 2'd1) && req_addr[0])
                        || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))))
             || (split_req && (!SPLIT_EN || (last_addr >= IO_BASE)));
  end

  // Little-endian reassembly: split beat i lands in lane i, native beats fill all lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_next[gi*8 +: 8] = !split_reg                ? mem_dout2[gi*8 +: 8] :
                                 (beat_reg == 2'(gi))      ? mem_dout2[7:0]       :
                                                             asm_reg[gi*8 +: 8];
  end

  assign wdata_byte = wdata_reg[{beat_reg, 3'b000} +: 8];

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      asm_reg       <= '0;
      size_reg      <= '0;
      beat_reg      <= '0;
      last_beat_reg <= '0;
      we_reg        <= 1'b0;
      sign_reg      <= 1'b0;
      split_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else if (accept) begin
      addr_reg      <= req_addr;
      wdata_reg     <= req_wdata;
      asm_reg       <= '0;
      size_reg      <= req_size;
      beat_reg      <= '0;
      last_beat_reg <= !split_req ? 2'd0 : ((req_size == 2'd1) ? 2'd1 : 2'd3);
      we_reg        <= req_we;
      sign_reg      <= req_sign;
      split_reg     <= split_req;
      err_reg       <= req_err;
    end else if (state_reg == ACCESS) begin
      asm_reg  <= asm_next;
      beat_reg <= beat_reg + 2'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (beat_reg == last_beat_reg) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == IDLE);
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    mem_addr2  = '0;
    mem_din2   = '0;
    mem_size   = '0;
    mem_sign   = 1'b0;
    case (state_reg)
      ACCESS: begin
        mem_rden2 = !we_reg;
        mem_we2   = we_reg;
        mem_addr2 = addr_reg + 32'(beat_reg);
        if (split_reg) begin
          mem_size = 2'd0;
          mem_sign = 1'b1;
          mem_din2 = {24'b0, wdata_byte};
        end else begin
          mem_size = size_reg;
          mem_sign = sign_reg;
          mem_din2 = wdata_reg;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        if (!we_reg && !err_reg) begin
          if (!split_reg || (size_reg == 2'd2)) resp_rdata = asm_reg;
          else if (sign_reg)                    resp_rdata = {16'b0, asm_reg[15:0]};
          else                                  resp_rdata = {{16{asm_reg[15]}}, asm_reg[15:0]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Directed bench for otter_lsu: byte-addressed memory model sampling on negedge,
// strobe logging, and hand-computed expectations for each request.
module tb_otter_lsu;

  localparam logic [31:0] IO = 32'h00010000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;

  logic        b_valid, b_ready, b_we, b_sign, b_resp_valid, b_resp_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [1:0]  b_size;
  logic        b_rden2, b_we2, b_msign;
  logic [31:0] b_maddr2, b_din2, b_dout2;
  logic [1:0]  b_msize;

  always #5 CLK = ~CLK;

  otter_lsu #(.IO_BASE(IO), .SPLIT_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2), .mem_din2(mem_din2),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_dout2(mem_dout2)
  );

  otter_lsu #(.IO_BASE(IO), .SPLIT_EN(1'b0)) dut_nosplit (
    .CLK(CLK), .RST(RST),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_size(b_size), .req_sign(b_sign), .req_wdata(b_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_err(b_resp_err),
    .mem_rden2(b_rden2), .mem_we2(b_we2), .mem_addr2(b_maddr2), .mem_din2(b_din2),
    .mem_size(b_msize), .mem_sign(b_msign), .mem_dout2(b_dout2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model
  logic [7:0]  ram [4096];
  logic [31:0] io_in;
  logic [31:0] log_addr [$];
  logic [31:0] log_din [$];
  logic [1:0]  log_size [$];
  logic        log_we [$];
  int          both_cnt = 0;
  int          b_strobe_cnt = 0;
  int          resp_cnt = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] raw;
    logic [11:0] i;
    i = a[11:0];
    if (a >= IO) raw = io_in;
    else raw = {ram[i + 12'd3], ram[i + 12'd2], ram[i + 12'd1], ram[i]};
    case (sz)
      2'd0:    return sg ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return sg ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (mem_rden2 || mem_we2) begin
      log_addr.push_back(mem_addr2);
      log_din.push_back(mem_din2);
      log_size.push_back(mem_size);
      log_we.push_back(mem_we2);
      if (mem_rden2 && mem_we2) both_cnt++;
    end
    if (mem_we2 && (mem_addr2 < IO)) begin
      ram[mem_addr2[11:0]] = mem_din2[7:0];
      if (mem_size != 2'd0) ram[mem_addr2[11:0] + 12'd1] = mem_din2[15:8];
      if (mem_size == 2'd2) begin
        ram[mem_addr2[11:0] + 12'd2] = mem_din2[23:16];
        ram[mem_addr2[11:0] + 12'd3] = mem_din2[31:24];
      end
    end
    if (mem_rden2) mem_dout2 <= mem_read(mem_addr2, mem_size, mem_sign);
    if (b_rden2 || b_we2) b_strobe_cnt++;
    if (resp_valid) resp_cnt++;
  end

  task automatic clear_log();
    log_addr.delete();
    log_din.delete();
    log_size.delete();
    log_we.delete();
    both_cnt = 0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    clear_log();
    @(posedge CLK); #1;
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_sign = sign; req_wdata = wdata;
    @(posedge CLK); #1;
    // scramble the fields: the block must hold what it sampled at accept
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_size = 2'd3;
    req_sign = ~sign; req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("resp_seen", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err = resp_err;
    check("ready_in_resp", 32'(req_ready), 32'd0);
    check("both_strobes", 32'(both_cnt), 32'd0);
    @(posedge CLK); #1;
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    $display("txn we=%0d addr=0x%08h size=%0d sign=%0d wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d beats=%0d",
             we, addr, size, sign, wdata, rdata, err, lat, log_addr.size());
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    RST = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_sign = 1'b0; req_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_size = '0; b_sign = 1'b0; b_wdata = '0;
    b_dout2 = '0; mem_dout2 = '0; io_in = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", {30'b0, mem_rden2, mem_we2}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    RST = 1'b0;

    // 1: native word load
    ram[12'h100] = 8'hEF; ram[12'h101] = 8'hBE; ram[12'h102] = 8'hAD; ram[12'h103] = 8'hDE;
    do_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, er, lt);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat", 32'(lt), 32'd2);
    check("lw_beats", 32'(log_addr.size()), 32'd1);
    check("lw_addr", log_addr[0], 32'h100);
    check("lw_size", 32'(log_size[0]), 32'd2);
    check("lw_is_read", 32'(log_we[0]), 32'd0);

    // native byte loads, signed and unsigned
    do_req(1'b0, 32'h100, 2'd0, 1'b0, 32'h0, rd, er, lt);
    check("lb_rdata", rd, 32'hFFFFFFEF);
    do_req(1'b0, 32'h100, 2'd0, 1'b1, 32'h0, rd, er, lt);
    check("lbu_rdata", rd, 32'h000000EF);

    // 2: split half load
    ram[12'h103] = 8'h34; ram[12'h104] = 8'h92;
    do_req(1'b0, 32'h103, 2'd1, 1'b0, 32'h0, rd, er, lt);
    check("lh_split_rdata", rd, 32'hFFFF9234);
    check("lh_split_lat", 32'(lt), 32'd3);
    check("lh_split_beats", 32'(log_addr.size()), 32'd2);
    check("lh_beat0_addr", log_addr[0], 32'h103);
    check("lh_beat1_addr", log_addr[1], 32'h104);
    check("lh_beat_size", 32'(log_size[1]), 32'd0);
    do_req(1'b0, 32'h103, 2'd1, 1'b1, 32'h0, rd, er, lt);
    check("lhu_split_rdata", rd, 32'h00009234);
    check("lhu_split_lat", 32'(lt), 32'd3);

    // 3: split word store then aligned read-back
    do_req(1'b1, 32'h202, 2'd2, 1'b0, 32'h11223344, rd, er, lt);
    check("sw_split_lat", 32'(lt), 32'd5);
    check("sw_split_rdata", rd, 32'd0);
    check("sw_split_beats", 32'(log_addr.size()), 32'd4);
    check("sw_beat3_addr", log_addr[3], 32'h205);
    check("sw_beat0_din", log_din[0], 32'h44);
    check("sw_beat2_din", log_din[2], 32'h22);
    check("sw_beat_is_write", 32'(log_we[1]), 32'd1);
    check("ram_202", 32'(ram[12'h202]), 32'h44);
    check("ram_205", 32'(ram[12'h205]), 32'h11);
    do_req(1'b0, 32'h204, 2'd2, 1'b0, 32'h0, rd, er, lt);
    check("readback_rdata", rd, 32'h00001122);

    // native byte store
    do_req(1'b1, 32'h40, 2'd0, 1'b0, 32'hAB12347E, rd, er, lt);
    check("sb_lat", 32'(lt), 32'd2);
    check("sb_ram_40", 32'(ram[12'h40]), 32'h7E);
    check("sb_ram_41", 32'(ram[12'h41]), 32'h00);

    // 4: rejected requests
    do_req(1'b0, 32'h0000FFFE, 2'd2, 1'b0, 32'h0, rd, er, lt);
    check("err_cross_io", 32'(er), 32'd1);
    check("err_cross_io_lat", 32'(lt), 32'd1);
    check("err_cross_io_beats", 32'(log_addr.size()), 32'd0);
    check("err_cross_io_rdata", rd, 32'd0);
    do_req(1'b1, 32'h00010001, 2'd1, 1'b0, 32'h5555, rd, er, lt);
    check("err_io_misaligned", 32'(er), 32'd1);
    check("err_io_misaligned_beats", 32'(log_addr.size()), 32'd0);
    do_req(1'b0, 32'h100, 2'd3, 1'b0, 32'h0, rd, er, lt);
    check("err_size3", 32'(er), 32'd1);
    check("err_size3_lat", 32'(lt), 32'd1);
    check("err_size3_beats", 32'(log_addr.size()), 32'd0);

    // 5: split disabled, and native IO byte load
    @(posedge CLK); #1;
    b_valid = 1'b1; b_addr = 32'h101; b_size = 2'd2; b_sign = 1'b0;
    @(posedge CLK); #1;
    b_valid = 1'b0;
    check("nosplit_resp", 32'(b_resp_valid), 32'd1);
    check("nosplit_err", 32'(b_resp_err), 32'd1);
    @(posedge CLK); #1;
    check("nosplit_strobes", 32'(b_strobe_cnt), 32'd0);
    $display("txn nosplit lw addr=0x00000101 -> err=1 expected, strobes=%0d", b_strobe_cnt);

    io_in = 32'h000000A5;
    do_req(1'b0, 32'h00010000, 2'd0, 1'b0, 32'h0, rd, er, lt);
    check("io_lb_rdata", rd, 32'hFFFFFFA5);
    check("io_lb_lat", 32'(lt), 32'd2);
    check("io_lb_addr", log_addr[0], 32'h00010000);

    // 6: reset during a split store after two beats
    ram[12'h301] = 8'h5A; ram[12'h302] = 8'h5A; ram[12'h303] = 8'h5A; ram[12'h304] = 8'h5A;
    clear_log();
    resp_cnt = 0;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h301; req_size = 2'd2; req_wdata = 32'hAABBCCDD;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp", 32'(resp_cnt), 32'd0);
    check("abort_beats", 32'(log_addr.size()), 32'd2);
    check("abort_ram_301", 32'(ram[12'h301]), 32'hDD);
    check("abort_ram_302", 32'(ram[12'h302]), 32'hCC);
    check("abort_ram_303", 32'(ram[12'h303]), 32'h5A);
    check("abort_ram_304", 32'(ram[12'h304]), 32'h5A);
    $display("txn aborted split sw addr=0x00000301 beats=%0d resp=%0d", log_addr.size(), resp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
